// File: rtl/module_multicycle_adder.sv
// module_multicycle_adder: multi-cycle ripple adder with valid/ready handshakes.
// One CHUNK-bit adder slice is reused for WIDTH/CHUNK cycles, trading latency for
// area. The FSM walks IDLE -> ADD (NCHUNK cycles) -> DONE -> IDLE.
// Optional build macro MULTICYCLE_ADDER_SUB_EN adds a sub_i port that turns the
// operation into A - B - carry_i (carry_o = 1 means no borrow).
module module_multicycle_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
`ifdef MULTICYCLE_ADDER_SUB_EN
  input  logic             sub_i,
`endif
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

  // Reject geometries the slice walk cannot cover exactly.
  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("module_multicycle_adder: need WIDTH>=1, 1<=CHUNK<=WIDTH, WIDTH%%CHUNK==0");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cry_q, cry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_out_q, carry_out_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  // Operand conditioning at accept time: subtraction is A + ~B + ~cin.
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
`ifdef MULTICYCLE_ADDER_SUB_EN
  assign b_in   = b_i ^ {WIDTH{sub_i}};
  assign cin_in = carry_i ^ sub_i;
`else
  assign b_in   = b_i;
  assign cin_in = carry_i;
`endif

  // Shared adder slice on the chunk selected by idx_q.
  logic [31:0]      base;
  logic [CHUNK-1:0] a_sl, b_sl;
  logic [CHUNK:0]   slice_sum;

  always_comb begin
    base      = 32'(idx_q) * 32'(CHUNK);
    a_sl      = CHUNK'(a_q >> base);
    b_sl      = CHUNK'(b_q >> base);
    slice_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, cry_q};
  end

  // Next-state and datapath update for the IDLE/ADD/DONE sequence.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cry_d       = cry_q;
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
    idx_d       = idx_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          a_d     = a_i;
          b_d     = b_in;
          cry_d   = cin_in;
          idx_d   = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        sum_d = (sum_q & ~(SLICE_MASK << base))
              | (WIDTH'(slice_sum[CHUNK-1:0]) << base);
        cry_d = slice_sum[CHUNK];
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          carry_out_d = slice_sum[CHUNK];
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Handshake outputs are decoded from the next state so they come straight off flops.
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cry_q       <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cry_q       <= cry_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign sum_o       = sum_q;
  assign carry_o     = carry_out_q;

endmodule

// File: tb/tb_module_multicycle_adder.sv
// Directed testbench for module_multicycle_adder: reset, wrap-around, backpressure,
// reset mid-operation and a (WIDTH,CHUNK) sweep over four instances.
module tb_module_multicycle_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance 0: WIDTH=8, CHUNK=2 (main DUT, own control)
  logic       rst0, iv0, c0, ordy0, ir0, ov0, co0;
  logic [7:0] a0, b0, s0;
`ifdef MULTICYCLE_ADDER_SUB_EN
  logic       sub0;
  logic       subg;
`endif
  // Sweep group: shared control for instances 1..3
  logic        rstg, ivg, cg, c16, ordyg;
  logic [7:0]  ag, bg;
  logic [15:0] a16, b16;
  logic        ir1, ov1, co1, ir2, ov2, co2, ir3, ov3, co3;
  logic [7:0]  s1, s2;
  logic [15:0] s3;

  module_multicycle_adder #(.WIDTH(8), .CHUNK(2)) u0 (
    .clk_i(clk), .rst_n_i(rst0), .in_valid_i(iv0), .in_ready_o(ir0),
    .a_i(a0), .b_i(b0), .carry_i(c0),
`ifdef MULTICYCLE_ADDER_SUB_EN
    .sub_i(sub0),
`endif
    .out_valid_o(ov0), .out_ready_i(ordy0), .sum_o(s0), .carry_o(co0));

  module_multicycle_adder #(.WIDTH(8), .CHUNK(8)) u1 (
    .clk_i(clk), .rst_n_i(rstg), .in_valid_i(ivg), .in_ready_o(ir1),
    .a_i(ag), .b_i(bg), .carry_i(cg),
`ifdef MULTICYCLE_ADDER_SUB_EN
    .sub_i(subg),
`endif
    .out_valid_o(ov1), .out_ready_i(ordyg), .sum_o(s1), .carry_o(co1));

  module_multicycle_adder #(.WIDTH(8), .CHUNK(1)) u2 (
    .clk_i(clk), .rst_n_i(rstg), .in_valid_i(ivg), .in_ready_o(ir2),
    .a_i(ag), .b_i(bg), .carry_i(cg),
`ifdef MULTICYCLE_ADDER_SUB_EN
    .sub_i(subg),
`endif
    .out_valid_o(ov2), .out_ready_i(ordyg), .sum_o(s2), .carry_o(co2));

  module_multicycle_adder #(.WIDTH(16), .CHUNK(4)) u3 (
    .clk_i(clk), .rst_n_i(rstg), .in_valid_i(ivg), .in_ready_o(ir3),
    .a_i(a16), .b_i(b16), .carry_i(c16),
`ifdef MULTICYCLE_ADDER_SUB_EN
    .sub_i(subg),
`endif
    .out_valid_o(ov3), .out_ready_i(ordyg), .sum_o(s3), .carry_o(co3));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transaction on all four instances; checks latency and {carry,sum}.
  task automatic run_vec(input string tag,
                         input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic [8:0] e8,
                         input logic [15:0] x, input logic [15:0] y, input logic cx,
                         input logic [16:0] e16);
    int          lat [4];
    logic [16:0] res [4];
    for (int i = 0; i < 4; i++) begin
      lat[i] = 0;
      res[i] = '0;
    end
    check_eq({tag, "_rdy"}, {28'd0, ir0, ir1, ir2, ir3}, 32'hF);
    iv0 = 1'b1; a0 = a; b0 = b; c0 = c;
    ivg = 1'b1; ag = a; bg = b; cg = c; a16 = x; b16 = y; c16 = cx;
    @(posedge clk); #1;
    iv0 = 1'b0; ivg = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (ov0 && lat[0] == 0) begin lat[0] = k; res[0] = {8'd0, co0, s0}; end
      if (ov1 && lat[1] == 0) begin lat[1] = k; res[1] = {8'd0, co1, s1}; end
      if (ov2 && lat[2] == 0) begin lat[2] = k; res[2] = {8'd0, co2, s2}; end
      if (ov3 && lat[3] == 0) begin lat[3] = k; res[3] = {co3, s3}; end
    end
    check_eq({tag, "_lat_8_2"},  32'(lat[0]), 32'd4);
    check_eq({tag, "_lat_8_8"},  32'(lat[1]), 32'd1);
    check_eq({tag, "_lat_8_1"},  32'(lat[2]), 32'd8);
    check_eq({tag, "_lat_16_4"}, 32'(lat[3]), 32'd4);
    check_eq({tag, "_sum_8_2"},  32'(res[0]), 32'(e8));
    check_eq({tag, "_sum_8_8"},  32'(res[1]), 32'(e8));
    check_eq({tag, "_sum_8_1"},  32'(res[2]), 32'(e8));
    check_eq({tag, "_sum_16_4"}, 32'(res[3]), 32'(e16));
  endtask

  // Hand-computed vectors: {carry,sum} = a + b + cin
  logic [7:0]  va  [8] = '{8'hFF, 8'h5A, 8'h00, 8'hFF, 8'h80, 8'h12, 8'h7F, 8'hA5};
  logic [7:0]  vb  [8] = '{8'h01, 8'h33, 8'h00, 8'hFF, 8'h80, 8'h34, 8'h00, 8'h5A};
  logic        vc  [8] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
  logic [8:0]  ve  [8] = '{9'h100, 9'h08E, 9'h000, 9'h1FF, 9'h100, 9'h046, 9'h080, 9'h100};
  logic [15:0] wa  [8] = '{16'hFFFF, 16'h1234, 16'h8000, 16'h0F0F, 16'hABCD, 16'hFFFF, 16'h0000, 16'h7FFF};
  logic [15:0] wb  [8] = '{16'h0001, 16'h4321, 16'h8000, 16'hF0F0, 16'h1111, 16'hFFFF, 16'h0000, 16'h0001};
  logic        wc  [8] = '{1'b0,     1'b1,     1'b1,     1'b0,     1'b0,     1'b1,     1'b0,     1'b0};
  logic [16:0] we  [8] = '{17'h10000, 17'h05556, 17'h10001, 17'h0FFFF, 17'h0BCDE, 17'h1FFFF, 17'h00000, 17'h08000};

  initial begin
    int hits;
    rst0 = 1'b0; iv0 = 1'b0; a0 = '0; b0 = '0; c0 = 1'b0; ordy0 = 1'b1;
    rstg = 1'b0; ivg = 1'b0; ag = '0; bg = '0; cg = 1'b0; a16 = '0; b16 = '0; c16 = 1'b0;
    ordyg = 1'b1;
`ifdef MULTICYCLE_ADDER_SUB_EN
    sub0 = 1'b0; subg = 1'b0;
`endif

    // Reset held for two edges
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready",  32'(ir0), 32'd1);
    check_eq("rst_out_valid", 32'(ov0), 32'd0);
    check_eq("rst_sum",       32'(s0),  32'h00);
    check_eq("rst_carry",     32'(co0), 32'd0);
    check_eq("rst_sum_16",    {15'd0, co3, s3}, 32'd0);
    rst0 = 1'b1; rstg = 1'b1;
    @(posedge clk); #1;

    // Sweep over all instances with the directed table (includes wrap cases)
    for (int i = 0; i < 8; i++)
      run_vec($sformatf("vec%0d", i), va[i], vb[i], vc[i], ve[i], wa[i], wb[i], wc[i], we[i]);

    // Backpressure on instance 0
    ordy0 = 1'b0;
    iv0 = 1'b1; a0 = 8'h5A; b0 = 8'h33; c0 = 1'b1;
    @(posedge clk); #1;
    iv0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("bp_not_yet", 32'(ov0), 32'd0);
    @(posedge clk); #1;
    check_eq("bp_valid", 32'(ov0), 32'd1);
    check_eq("bp_sum",   {23'd0, co0, s0}, 32'h08E);
    iv0 = 1'b1; a0 = 8'hFF; b0 = 8'hFF; c0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq($sformatf("bp_hold_sum%0d", i), {23'd0, co0, s0}, 32'h08E);
      check_eq($sformatf("bp_hold_vld%0d", i), {30'd0, ov0, ir0}, 32'h2);
    end
    iv0 = 1'b0; ordy0 = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_release", {30'd0, ov0, ir0}, 32'h1);

    // Reset during the second ADD cycle discards the result
    iv0 = 1'b1; a0 = 8'h80; b0 = 8'h80; c0 = 1'b0;
    @(posedge clk); #1;
    iv0 = 1'b0;
    @(posedge clk); #1;
    rst0 = 1'b0;
    @(posedge clk); #1;
    rst0 = 1'b1;
    check_eq("mid_rst_state", {30'd0, ov0, ir0}, 32'h1);
    check_eq("mid_rst_sum",   {23'd0, co0, s0}, 32'h000);
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ov0) hits++;
    end
    check_eq("mid_rst_no_valid", 32'(hits), 32'd0);
    run_vec("after_rst", 8'h01, 8'h02, 1'b0, 9'h003, 16'h0001, 16'h0002, 1'b0, 17'h00003);

`ifdef MULTICYCLE_ADDER_SUB_EN
    // Subtract mode on instance 0: 0x10-0x01 and 0x00-0x01
    sub0 = 1'b1;
    iv0 = 1'b1; a0 = 8'h10; b0 = 8'h01; c0 = 1'b0;
    @(posedge clk); #1;
    iv0 = 1'b0; sub0 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("sub_vld0", 32'(ov0), 32'd1);
    check_eq("sub_res0", {23'd0, co0, s0}, 32'h10F);
    @(posedge clk); #1;
    sub0 = 1'b1;
    iv0 = 1'b1; a0 = 8'h00; b0 = 8'h01; c0 = 1'b0;
    @(posedge clk); #1;
    iv0 = 1'b0; sub0 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("sub_vld1", 32'(ov0), 32'd1);
    check_eq("sub_res1", {23'd0, co0, s0}, 32'h0FF);
    @(posedge clk); #1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Guard against a stuck simulation
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
